// File: rtl/instr_fetch_decode.sv
// ============================================================================
// Module   : instr_fetch_decode
// Purpose  : Instruction fetch, field decode and PC ownership for the 16-bit
//            CPU front end. Optional macro ILLEGAL_TRAP_EN adds a HALT state
//            entered after an illegal instruction is accepted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_decode #(
    parameter int          ADDR_W   = 16,
    parameter int          MEM_LAT  = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              dec_valid,
    input  logic              dec_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] pc_out,
    output logic [7:0]        opcode_out,
    output logic [15:0]       rdst_out,
    output logic [4:0]        rsrc_out,
    output logic [7:0]        imm_out,
    output logic              imm_sel,
    output logic [3:0]        flag_type,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam int                c_cnt_w    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3
`ifdef ILLEGAL_TRAP_EN
        ,S_HALT = 3'd4
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic                w_capture;

    logic [7:0]  r_opcode;
    logic [15:0] r_rdst;
    logic [4:0]  r_rsrc;
    logic [7:0]  r_imm;
    logic        r_imm_sel;
    logic [3:0]  r_flag;
    logic        r_illegal;

    logic [3:0]  w_dec_flag;
    logic        w_dec_imm_sel;
    logic        w_dec_illegal;

    // Instruction class from the major opcode and, for op 4, the extension nibble
    always_comb begin
        w_dec_flag    = 4'b0001;
        w_dec_imm_sel = 1'b1;
        w_dec_illegal = 1'b0;
        case (mem_rdata[15:12])
            4'h0: w_dec_imm_sel = 1'b0;
            4'h4: begin
                w_dec_imm_sel = 1'b0;
                case (mem_rdata[7:4])
                    4'h0:    w_dec_flag = 4'b0010;
                    4'h4:    w_dec_flag = 4'b0100;
                    4'hC:    w_dec_flag = 4'b1000;
                    default: begin
                        w_dec_flag    = 4'b0000;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
            4'hC:    w_dec_flag = 4'b1000;
            default: w_dec_flag = 4'b0001;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pc_load) begin
                    w_pc_nxt = pc_load_val;
                end else if (fetch_en) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_cnt_nxt = c_cnt_init;
                if (pc_load) begin
                    w_pc_nxt    = pc_load_val;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect beats the returning data: the read is dropped
                if (pc_load) begin
                    w_pc_nxt    = pc_load_val;
                    w_state_nxt = S_FETCH;
                end else if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            S_VALID: begin
                if (dec_ready) begin
                    w_pc_nxt    = pc_load ? pc_load_val : r_pc + ADDR_W'(1);
                    w_state_nxt = fetch_en ? S_FETCH : S_IDLE;
`ifdef ILLEGAL_TRAP_EN
                    if (r_illegal) begin
                        w_state_nxt = S_HALT;
                    end
`endif
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: w_state_nxt = S_HALT;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= c_reset_pc;
            r_cnt     <= '0;
            r_opcode  <= '0;
            r_rdst    <= '0;
            r_rsrc    <= '0;
            r_imm     <= '0;
            r_imm_sel <= 1'b0;
            r_flag    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_opcode  <= {mem_rdata[15:12], mem_rdata[7:4]};
                r_rdst    <= 16'h0001 << mem_rdata[11:8];
                r_rsrc    <= {1'b0, mem_rdata[3:0]};
                r_imm     <= mem_rdata[7:0];
                r_imm_sel <= w_dec_imm_sel;
                r_flag    <= w_dec_flag;
                r_illegal <= w_dec_illegal;
            end
        end
    end

    assign mem_rd_en  = (r_state == S_FETCH);
    assign mem_addr   = r_pc;
    assign dec_valid  = (r_state == S_VALID);
    assign pc_out     = r_pc;
    assign opcode_out = r_opcode;
    assign rdst_out   = r_rdst;
    assign rsrc_out   = r_rsrc;
    assign imm_out    = r_imm;
    assign imm_sel    = r_imm_sel;
    assign flag_type  = r_flag;
    assign illegal    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
// ============================================================================
// Module   : tb_instr_fetch_decode
// Purpose  : Randomized self-checking bench for instr_fetch_decode against a
//            transaction-level model (expected PC sequence + field table).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_decode;

    localparam int ADDR_W  = 16;
    localparam int MEM_LAT = 1;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] pc_out;
    logic [7:0]  opcode_out;
    logic [15:0] rdst_out;
    logic [4:0]  rsrc_out;
    logic [7:0]  imm_out;
    logic        imm_sel;
    logic [3:0]  flag_type;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_decode #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_out(pc_out),
        .opcode_out(opcode_out), .rdst_out(rdst_out), .rsrc_out(rsrc_out),
        .imm_out(imm_out), .imm_sel(imm_sel), .flag_type(flag_type),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: data for a read appears MEM_LAT cycles after the strobe
    logic [15:0] mem [0:65535];
    logic [15:0] r_pipe_addr [MEM_LAT];
    logic        r_pipe_v    [MEM_LAT];

    always @(posedge clk) begin
        r_pipe_addr[0] <= mem_addr;
        r_pipe_v[0]    <= mem_rd_en && !reset;
        for (int i = 1; i < MEM_LAT; i++) begin
            r_pipe_addr[i] <= r_pipe_addr[i-1];
            r_pipe_v[i]    <= r_pipe_v[i-1];
        end
    end
    assign mem_rdata = r_pipe_v[MEM_LAT-1] ? mem[r_pipe_addr[MEM_LAT-1]] : 16'hDEAD;

    logic [42:0] obs;
    assign obs = {opcode_out, rdst_out, rsrc_out, imm_out, imm_sel, flag_type, illegal};

    // Field table: {opcode, rdst, rsrc, imm, imm_sel, flag_type, illegal}
    function automatic logic [42:0] exp_fields(input logic [15:0] w);
        logic [3:0] op, ext, fl;
        logic       isel, ill;
        op = w[15:12];
        ext = w[7:4];
        ill = 1'b0;
        if (op == 4'h0) begin
            fl = 4'b0001; isel = 1'b0;
        end else if (op == 4'h4) begin
            isel = 1'b0;
            if (ext == 4'h0)      fl = 4'b0010;
            else if (ext == 4'h4) fl = 4'b0100;
            else if (ext == 4'hC) fl = 4'b1000;
            else begin fl = 4'b0000; ill = 1'b1; end
        end else if (op == 4'hC) begin
            fl = 4'b1000; isel = 1'b1;
        end else begin
            fl = 4'b0001; isel = 1'b1;
        end
        return {op, ext, 16'(1 << w[11:8]), {1'b0, w[3:0]}, w[7:0], isel, fl, ill};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic ld, input logic [15:0] val);
        dec_ready   = 1'b1;
        pc_load     = ld;
        pc_load_val = val;
        tick();
        dec_ready   = 1'b0;
        pc_load     = 1'b0;
    endtask

    task automatic fetch_and_check(input string tag, input logic [15:0] a);
        int n;
        n = 0;
        while (!mem_rd_en && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_fetch_seen"}, 64'(mem_rd_en), 64'(1));
        check({tag, "_fetch_addr"}, 64'(mem_addr), 64'(a));
        n = 0;
        do begin
            tick();
            n++;
        end while (!dec_valid && n < 20);
        check({tag, "_latency"}, 64'(n), 64'(MEM_LAT + 1));
        check({tag, "_pc_out"}, 64'(pc_out), 64'(a));
        check({tag, "_fields"}, 64'(obs), 64'(exp_fields(mem[a])));
    endtask

    logic [60:0] snap;
    logic [15:0] model_pc;
    logic [15:0] w;
    logic        ld;
    logic [15:0] val;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'h4 && !(w[7:4] inside {4'h0, 4'h4, 4'hC})) w[7:4] = 4'h0;
            mem[i] = w;
        end
        mem[0]     = 16'h0351;
        mem[1]     = 16'h4A01;
        mem[2]     = 16'h5207;
        mem[16'h40] = 16'hC0FE;
        mem[16'h80] = 16'h0123;

        reset = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        repeat (3) tick();
        check("rst_ctrl", 64'({dec_valid, mem_rd_en}), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_fields", 64'(obs), 64'(0));

        // Cycle 0 after reset release
        reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
        tick();
        check("c1_rd_en", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 16'h0000}));
        tick();
        check("c2_valid", 64'(dec_valid), 64'(0));
        tick();
        check("c3_valid", 64'(dec_valid), 64'(1));
        check("c3_fields", 64'(obs), 64'({8'h05, 16'h0008, 5'h01, 8'h51, 1'b0, 4'b0001, 1'b0}));
        check("c3_pc", 64'(pc_out), 64'(0));
        tick();
        dec_ready = 1'b0;

        fetch_and_check("load", 16'h0001);
        check("load_const", 64'({flag_type, rdst_out, rsrc_out}), 64'({4'b0010, 16'h0400, 5'h01}));
        accept(1'b0, '0);
        fetch_and_check("immalu", 16'h0002);
        check("imm_const", 64'({flag_type, imm_sel, imm_out}), 64'({4'b0001, 1'b1, 8'h07}));
        accept(1'b0, '0);

        // Stall in VALID
        fetch_and_check("stall", 16'h0003);
        snap = {obs, pc_out, 2'b00};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", 64'({obs, pc_out, dec_valid, mem_rd_en}), 64'(snap | 61'b10));
        end
        accept(1'b0, '0);
        fetch_and_check("after_stall", 16'h0004);

        // Redirect on accept, then redirect during WAIT
        accept(1'b1, 16'h0040);
        check("redir_valid", 64'({mem_rd_en, mem_addr}), 64'({1'b1, 16'h0040}));
        tick();
        pc_load = 1'b1; pc_load_val = 16'h0080;
        tick();
        pc_load = 1'b0;
        fetch_and_check("redir_wait", 16'h0080);

        // PC wrap
        accept(1'b1, 16'hFFFF);
        fetch_and_check("pc_top", 16'hFFFF);
        accept(1'b0, '0);
        fetch_and_check("pc_wrap", 16'h0000);

        // fetch_en low parks in IDLE; redirect while idle
        fetch_en = 1'b0;
        accept(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_quiet", 64'({dec_valid, mem_rd_en}), 64'(0));
        end
        pc_load = 1'b1; pc_load_val = 16'h0200;
        tick();
        pc_load = 1'b0;
        tick();
        check("idle_load_quiet", 64'(mem_rd_en), 64'(0));
        fetch_en = 1'b1;
        fetch_and_check("idle_load", 16'h0200);

        // Reset during WAIT
        accept(1'b0, '0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wait_valid", 64'(dec_valid), 64'(0));
        fetch_and_check("rst_wait_refetch", 16'h0000);

        // Random traffic against the PC-sequence model
        model_pc = 16'h0000;
        for (int k = 0; k < 60; k++) begin
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                tick();
                check("rnd_stall", 64'({dec_valid, mem_rd_en}), 64'(2'b10));
            end
            ld  = ($urandom_range(0, 3) == 0);
            val = 16'($urandom);
            accept(ld, val);
            model_pc = ld ? val : model_pc + 16'd1;
            fetch_and_check("rnd", model_pc);
        end

        // Illegal instruction
        mem[16'h0100] = 16'h4A21;
        accept(1'b1, 16'h0100);
        fetch_and_check("illegal", 16'h0100);
        check("illegal_const", 64'({flag_type, illegal}), 64'({4'b0000, 1'b1}));
        accept(1'b0, '0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            pc_load = (i == 4); pc_load_val = 16'h0300;
            tick();
            check("halt", 64'({mem_rd_en, dec_valid, illegal}), 64'(3'b001));
        end
        pc_load = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_and_check("halt_reset", 16'h0000);
`else
        fetch_and_check("illegal_next", 16'h0101);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
